// File: rtl/fsub_seq.sv
// Iterative IEEE-754 subtractor (a - b): unpack, one-bit-per-cycle align and normalise, truncating pack.
// Special cases and truncation match the companion fadd so add/sub results stay bit-consistent.
module fsub_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);
    localparam int EXP_W = (N == 64) ? 11 : 8;
    localparam int MAN_W = (N == 64) ? 52 : 23;
    localparam int MW    = MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_TOP  = EXP_ONES - 1'b1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] FAR_LIM  = EXP_W'(MAN_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    function automatic logic [N-1:0] sat_inf(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [N-1:0] signed_zero(input logic s);
        return {s, {(N-1){1'b0}}};
    endfunction

    state_t            state_q, state_d;
    logic [N-1:0]      opa_q, opa_d, opb_q, opb_d;
    logic [N-1:0]      res_q, res_d;
    logic [MW-1:0]     mx_q, mx_d, my_q, my_d;
    logic [EXP_W-1:0]  cnt_q, cnt_d, exp_q, exp_d;
    logic              sign_q, sign_d, sub_q, sub_d;

    logic              sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge, far;
    logic [EXP_W-1:0]  ea, eb, ediff;
    logic [MAN_W-1:0]  fa, fb;
    logic [MW-1:0]     sum_m;

    // opb_q already holds the sign-flipped subtrahend, so the rest is an add
    assign sa     = opa_q[N-1];
    assign sb     = opb_q[N-1];
    assign ea     = opa_q[N-2:MAN_W];
    assign eb     = opb_q[N-2:MAN_W];
    assign fa     = opa_q[MAN_W-1:0];
    assign fb     = opb_q[MAN_W-1:0];
    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    assign a_zero = !(|ea);
    assign b_zero = !(|eb);
    assign a_ge   = opa_q[N-2:0] >= opb_q[N-2:0];
    assign ediff  = a_ge ? (ea - eb) : (eb - ea);
    assign far    = ediff > FAR_LIM;
    assign sum_m  = sub_q ? (mx_q - my_q) : (mx_q + my_q);

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        mx_d    = mx_q;
        my_d    = my_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    opa_d   = a;
                    opb_d   = {~b[N-1], b[N-2:0]};
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                state_d = S_DONE;
                if (a_nan || b_nan) begin
                    res_d = '1;
                end else if (a_inf || b_inf) begin
                    res_d = (a_inf && b_inf && (sa != sb)) ? '1 : (a_inf ? opa_q : opb_q);
                end else if (a_zero || b_zero) begin
                    res_d = (a_zero && b_zero) ? signed_zero(sa & sb) : (a_zero ? opb_q : opa_q);
                end else if (far) begin
                    res_d = a_ge ? opa_q : opb_q;
                end else begin
                    mx_d    = {2'b01, (a_ge ? fa : fb)};
                    my_d    = {2'b01, (a_ge ? fb : fa)};
                    exp_d   = a_ge ? ea : eb;
                    sign_d  = a_ge ? sa : sb;
                    sub_d   = sa ^ sb;
                    cnt_d   = ediff;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (cnt_q == '0) begin
                    state_d = S_ADD;
                end else begin
                    my_d  = my_q >> 1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ADD: begin
                mx_d = sum_m;
                if (sum_m == '0) begin
                    res_d   = '0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (mx_q[MW-1]) begin
                    mx_d  = mx_q >> 1;
                    exp_d = exp_q + 1'b1;
                    if (exp_q == EXP_TOP) begin
                        res_d   = sat_inf(sign_q);
                        state_d = S_DONE;
                    end
                end else if (!mx_q[MAN_W]) begin
                    mx_d  = mx_q << 1;
                    exp_d = exp_q - 1'b1;
                    if (exp_q == EXP_ONE) begin
                        res_d   = signed_zero(sign_q);
                        state_d = S_DONE;
                    end
                end else begin
                    res_d   = {sign_q, exp_q, mx_q[MAN_W-1:0]};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        mx_q   <= mx_d;
        my_q   <= my_d;
        cnt_q  <= cnt_d;
        exp_q  <= exp_d;
        sign_q <= sign_d;
        sub_q  <= sub_d;
    end

endmodule

// File: tb/tb_fsub_seq.sv
// Bench for fsub_seq (N=32): directed literal cases plus randomized operands checked
// every cycle against an arithmetic reference model with a pending-operation queue.
module tb_fsub_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    int          nchk = 0;
    int          nerr = 0;
    int          cyc  = 0;

    typedef struct packed {
        logic [31:0] r;
        int          lat;
        bit          sp;
        int          acc;
    } exp_t;

    exp_t        q[$];
    bit          held_ov = 1'b0;
    logic [31:0] held_r  = '0;
    logic [31:0] sp_tab [8];

    fsub_seq #(.N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // a - b evaluated as plain arithmetic on the unpacked fields; lat counts edges from accept to out_valid
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output int lat, output bit sp);
        logic [31:0] yb;
        int ea, eb, fa, fb, d, sh, e, mx, my, m, n;
        bit s, xa;
        yb  = {~y[31], y[30:0]};
        ea  = int'(x[30:23]);
        fa  = int'(x[22:0]);
        eb  = int'(yb[30:23]);
        fb  = int'(yb[22:0]);
        sp  = 1'b1;
        lat = 1;
        r   = '0;
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) begin
            r = 32'hFFFF_FFFF;
        end else if (ea == 255 || eb == 255) begin
            if (ea == 255 && eb == 255 && x[31] != yb[31]) r = 32'hFFFF_FFFF;
            else r = (ea == 255) ? x : yb;
        end else if (ea == 0 || eb == 0) begin
            if (ea == 0 && eb == 0) r = {x[31] & yb[31], 31'd0};
            else r = (ea == 0) ? yb : x;
        end else begin
            d = ea - eb;
            if (d > 22 || d < -22) begin
                r = (d > 0) ? x : yb;
            end else begin
                sp  = 1'b0;
                xa  = (x[30:0] >= yb[30:0]);
                s   = xa ? x[31] : yb[31];
                e   = xa ? ea : eb;
                sh  = (d < 0) ? -d : d;
                mx  = (1 << 23) + (xa ? fa : fb);
                my  = ((1 << 23) + (xa ? fb : fa)) >> sh;
                m   = (x[31] == yb[31]) ? mx + my : mx - my;
                lat = 3 + sh;
                if (m != 0) begin
                    n = 0;
                    for (int i = 0; i < 64; i++) begin
                        n++;
                        if (m >= (1 << 24)) begin
                            m = m >> 1;
                            e++;
                            if (e == 255) begin r = {s, 8'hFF, 23'd0}; break; end
                        end else if (m < (1 << 23)) begin
                            m = m << 1;
                            e--;
                            if (e == 0) begin r = {s, 31'd0}; break; end
                        end else begin
                            r = {s, 8'(e), 23'(m)};
                            break;
                        end
                    end
                    lat += n;
                end
            end
        end
    endfunction

    function automatic logic [31:0] mk(input bit s, input int e, input logic [22:0] m);
        return {s, 8'(e), m};
    endfunction

    function automatic int clip(input int v);
        return (v < 1) ? 1 : ((v > 254) ? 254 : v);
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] mr;
        int          ml, lat;
        bit          msp;
        if (rst) begin
            chk(!in_ready, "in_ready_in_reset", 32'(in_ready), 32'd0);
            q.delete();
            held_ov = 1'b0;
        end else begin
            if (out_valid) begin
                chk(!in_ready, "in_ready_while_done", 32'(in_ready), 32'd0);
                if (!held_ov) begin
                    chk(q.size() != 0, "valid_without_op", 32'(q.size()), 32'd1);
                    if (q.size() != 0) begin
                        e   = q.pop_front();
                        lat = cyc - e.acc;
                        chk(result == e.r, "result", result, e.r);
                        if (e.sp) chk(lat >= 1 && lat <= 2, "latency_special", 32'(lat), 32'd2);
                        else chk(lat == e.lat, "latency", 32'(lat), 32'(e.lat));
                        held_r = e.r;
                    end
                end else begin
                    chk(result == held_r, "result_hold", result, held_r);
                end
            end else if (q.size() != 0 && (cyc - q[0].acc) > 400) begin
                chk(1'b0, "result_timeout", 32'(cyc - q[0].acc), 32'd400);
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                model(a, b, mr, ml, msp);
                q.push_back('{r: mr, lat: ml, sp: msp, acc: cyc + 1});
            end
            held_ov = out_valid && !out_ready;
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        bit got = 1'b0;
        a = x;
        b = y;
        in_valid = 1'b1;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk(got, "accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_done(output logic [31:0] r, input bit rnd);
        bit got = 1'b0;
        r = '0;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got = 1'b1;
                r   = result;
            end else if (rnd) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk(got, "done_timeout", 32'(got), 32'd1);
    endtask

    task automatic run_dir(input logic [31:0] x, input logic [31:0] y, input logic [31:0] lit, input string nm);
        logic [31:0] r;
        send(x, y);
        wait_done(r, 1'b0);
        chk(r == lit, nm, r, lit);
    endtask

    initial begin
        logic [31:0] r, x, y;
        int          ml, sel, e1, e2;
        bit          msp, s1, s2, seen, got;

        sp_tab = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                   32'h7FC0_0000, 32'hFF80_0001, 32'h3F80_0000, 32'hBF80_0000};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;

        model(32'h4040_0000, 32'h3F80_0000, r, ml, msp);
        chk(r == 32'h4000_0000 && ml == 5, "model_3m1", r, 32'h4000_0000);
        model(32'h3F80_0000, 32'h3FC0_0000, r, ml, msp);
        chk(r == 32'hBF00_0000 && ml == 5, "model_1m1p5", r, 32'hBF00_0000);
        model(32'h3F80_0000, 32'h3F80_0000, r, ml, msp);
        chk(r == 32'h0000_0000 && ml == 3, "model_1m1", r, 32'h0);
        model(32'h7F00_0000, 32'hFF00_0000, r, ml, msp);
        chk(r == 32'h7F80_0000 && ml == 4, "model_ovf", r, 32'h7F80_0000);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(result == 32'h0, "reset_result", result, 32'h0);
        chk(!out_valid, "reset_out_valid", 32'(out_valid), 32'd0);
        chk(in_ready, "idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        run_dir(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, "t1_3m1");
        run_dir(32'h3F80_0000, 32'h3FC0_0000, 32'hBF00_0000, "t2_1m1p5");
        run_dir(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, "t3_carry");
        run_dir(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, "t3_cancel");
        run_dir(32'h7F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF, "t4_inf_inf");
        run_dir(32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, "inf_same_sign");
        run_dir(32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, "t4_nan");
        run_dir(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, "t4_far24");
        run_dir(32'h4B00_0000, 32'h3F80_0000, 32'h4B00_0000, "far23");
        run_dir(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "zero_m_zero");
        run_dir(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, "nzero_m_zero");
        run_dir(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, "x_m_zero");
        run_dir(32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, "zero_m_x");
        run_dir(32'h7F00_0000, 32'hFF00_0000, 32'h7F80_0000, "overflow_inf");
        run_dir(32'h0080_0001, 32'h0080_0000, 32'h0000_0000, "underflow_zero");

        // result held while downstream stalls; a waiting operand must not be taken
        out_ready = 1'b0;
        send(32'h4040_0000, 32'h3F80_0000);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk(got, "stall_valid", 32'(got), 32'd1);
        a = 32'h3F80_0000; b = 32'h3FC0_0000; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk(out_valid, "stall_out_valid", 32'(out_valid), 32'd1);
            chk(result == 32'h4000_0000, "stall_result", result, 32'h4000_0000);
            chk(!in_ready, "stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk(got, "stall_next_accept", 32'(got), 32'd1);
        wait_done(r, 1'b0);
        chk(r == 32'hBF00_0000, "stall_next_result", r, 32'hBF00_0000);

        // reset while shifting through a 22-step alignment
        send(32'h4A80_0000, 32'h3F80_0000);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        chk(in_ready, "idle_after_rst", 32'(in_ready), 32'd1);
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk(!seen, "rst_discards_op", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        run_dir(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, "t6_after_rst");

        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 15));
            s1  = 1'($urandom_range(0, 1));
            s2  = 1'($urandom_range(0, 1));
            e1  = int'($urandom_range(1, 254));
            e2  = clip(e1 + int'($urandom_range(0, 6)) - 3);
            x   = mk(s1, e1, 23'($urandom));
            y   = mk(s2, e2, 23'($urandom));
            case (sel)
                0: y = x;
                1: y = x ^ 32'h8000_0000;
                2: y = sp_tab[$urandom_range(0, 7)];
                3: x = sp_tab[$urandom_range(0, 7)];
                4: begin
                    x = mk(s1, int'($urandom_range(1, 3)), 23'($urandom));
                    y = mk(s1, int'($urandom_range(1, 2)), 23'($urandom));
                end
                5: begin
                    x = mk(s1, int'($urandom_range(252, 254)), 23'($urandom));
                    y = mk(~s1, int'($urandom_range(252, 254)), 23'($urandom));
                end
                6: y = mk(s2, clip(e1 + (($urandom_range(0, 1) != 0) ? 1 : -1) * int'($urandom_range(21, 25))), 23'($urandom));
                default: ;
            endcase
            send(x, y);
            wait_done(r, 1'b1);
        end

        repeat (3) @(posedge clk);
        chk(q.size() == 0, "queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
